// File: rtl/keypad_digit_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_digit_scanner_if
//  Description : Key input and multiplexed display bus of keypad_digit_scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_digit_scanner_if #(
    parameter int DIGITS = 4
);
    logic [3:0]                      key_code;
    logic                            key_valid;
    logic [3:0]                      digit_nib;
    logic [DIGITS-1:0]               anode;
    logic                            blank;
    logic [$clog2(DIGITS+1)-1:0]     entry_count;
    logic                            press_pulse;

    // master: keypad scanner / display side; slave: the digit scanner itself
    modport master (
        output key_code, key_valid,
        input  digit_nib, anode, blank, entry_count, press_pulse
    );

    modport slave (
        input  key_code, key_valid,
        output digit_nib, anode, blank, entry_count, press_pulse
    );
endinterface
`default_nettype wire

// File: rtl/keypad_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_digit_scanner
//  Description : Debounces keypad codes into a DIGITS-deep shift buffer and
//                time-multiplexes it onto a common-anode display.
//                Optional macro KEYPAD_CLEAR_KEY_EN: code 4'hC clears buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_scanner #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int REFRESH_DIV   = 100000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    keypad_digit_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int ENT_W = $clog2(DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [ENT_W-1:0] ENT_FULL   = ENT_W'(DIGITS);
    localparam logic [3:0]       CLEAR_CODE = 4'hC;

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cand_q, cand_d;
    logic              accept_q, accept_d;
    logic              press_pulse_q, press_pulse_d;
    logic [3:0]        digit_buf_q [DIGITS];
    logic [3:0]        digit_buf_d [DIGITS];
    logic [ENT_W-1:0]  entry_count_q, entry_count_d;
    logic [REF_W-1:0]  refresh_q, refresh_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [3:0]        digit_nib_q, digit_nib_d;
    logic              blank_q, blank_d;
    logic              do_clear;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.key_valid) begin
                    state_d = S_PRESS_WAIT;
                    cand_d  = bus.key_code;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!bus.key_valid || (bus.key_code != cand_q)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_HELD;
                    accept_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                // Code changes while held are deliberately ignored.
                if (!bus.key_valid) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (bus.key_valid) begin
                    state_d = S_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef KEYPAD_CLEAR_KEY_EN
    assign do_clear = (cand_q == CLEAR_CODE);
`else
    assign do_clear = 1'b0;
`endif

    always_comb begin
        digit_buf_d   = digit_buf_q;
        entry_count_d = entry_count_q;
        press_pulse_d = accept_q;
        if (accept_d && do_clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_d[i] = 4'h0;
            end
            entry_count_d = '0;
        end else if (accept_d) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                digit_buf_d[i] = digit_buf_q[i-1];
            end
            digit_buf_d[0] = cand_q;
            if (entry_count_q != ENT_FULL) begin
                entry_count_d = entry_count_q + ENT_W'(1);
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + REF_W'(1);
        idx_d     = idx_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // Display registers sample the current index and buffer, one cycle behind.
        anode_d     = ~(DIGITS'(1) << idx_q);
        digit_nib_d = digit_buf_q[idx_q];
        blank_d     = (ENT_W'(idx_q) >= entry_count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cand_q        <= 4'h0;
            accept_q      <= 1'b0;
            press_pulse_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_q[i] <= 4'h0;
            end
            entry_count_q <= '0;
            refresh_q     <= '0;
            idx_q         <= '0;
            anode_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
            digit_nib_q   <= 4'h0;
            blank_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            accept_q      <= accept_d;
            press_pulse_q <= press_pulse_d;
            digit_buf_q   <= digit_buf_d;
            entry_count_q <= entry_count_d;
            refresh_q     <= refresh_d;
            idx_q         <= idx_d;
            anode_q       <= anode_d;
            digit_nib_q   <= digit_nib_d;
            blank_q       <= blank_d;
        end
    end

    assign bus.digit_nib   = digit_nib_q;
    assign bus.anode       = anode_q;
    assign bus.blank       = blank_q;
    assign bus.entry_count = entry_count_q;
    assign bus.press_pulse = press_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_digit_scanner
//  Description : Self-checking bench for keypad_digit_scanner (4 digits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_scanner;

    localparam int D = 4;
    localparam int S = 4;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_digit_scanner_if #(.DIGITS(D)) kif ();

    keypad_digit_scanner #(
        .DIGITS(D), .STABLE_CYCLES(S), .REFRESH_DIV(R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: run lengths of stable samples, digit list, scan = elapsed cycles / R
    bit m_on = 0;
    int m_n, m_count, m_cand, m_run, m_low, m_idx;
    int m_buf [D];
    bit m_held, m_acc, m_acc_prev;
    int e_anode, e_nib, e_blank, e_pulse, e_count;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1; m_n = 0; m_count = 0; m_run = 0; m_low = 0; m_cand = 0;
            m_held = 0; m_acc_prev = 0;
            for (int i = 0; i < D; i++) m_buf[i] = 0;
            e_anode = 4'b1110; e_nib = 0; e_blank = 1; e_pulse = 0; e_count = 0;
        end else begin
            m_idx   = (m_n / R) % D;
            e_anode = ~(1 << m_idx) & 4'hF;
            e_nib   = m_buf[m_idx];
            e_blank = (m_idx >= m_count) ? 1 : 0;
            e_pulse = m_acc_prev ? 1 : 0;
            m_acc   = 0;
            if (!m_held) begin
                if (kif.key_valid && m_run > 0 && kif.key_code == m_cand) begin
                    m_run++;
                    if (m_run == S + 1) begin m_acc = 1; m_held = 1; m_low = 0; end
                end else if (kif.key_valid && m_run == 0) begin
                    m_cand = kif.key_code; m_run = 1;
                end else begin
                    m_run = 0;
                end
            end else if (kif.key_valid) begin
                m_low = 0;
            end else begin
                m_low++;
                if (m_low == S + 1) begin m_held = 0; m_run = 0; end
            end
            if (m_acc) begin
`ifdef KEYPAD_CLEAR_KEY_EN
                if (m_cand == 12) begin
                    for (int i = 0; i < D; i++) m_buf[i] = 0;
                    m_count = 0;
                end else begin
`endif
                    for (int i = D - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                    m_buf[0] = m_cand;
                    if (m_count < D) m_count++;
`ifdef KEYPAD_CLEAR_KEY_EN
                end
`endif
            end
            e_count    = m_count;
            m_acc_prev = m_acc;
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_anode", 32'(kif.anode), e_anode);
            check("model_blank", 32'(kif.blank), e_blank);
            if (!kif.blank) check("model_nib", 32'(kif.digit_nib), e_nib);
            check("model_pulse", 32'(kif.press_pulse), e_pulse);
            check("model_count", 32'(kif.entry_count), e_count);
            if (kif.press_pulse === 1'b1) pulses_seen++;
        end
    end

    typedef struct {
        bit         valid;
        logic [3:0] code;
        bit         exp_pulse;
        int         exp_count;
    } vec_t;

    vec_t tv [46];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; kif.key_valid = 1'b0; kif.key_code = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        kif.key_valid = 1'b1; kif.key_code = code;
        repeat (6) @(negedge clk);
        kif.key_valid = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    // nibs[4j+:4] is the expected nibble while anode j is active
    task automatic scan_check(input string tag, input logic [15:0] nibs, input logic [3:0] blanks);
        logic [3:0] seen;
        int         j;
        seen = 4'h0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            j = -1;
            for (int k = 0; k < D; k++) if (kif.anode == ~(4'b0001 << k)) j = k;
            check({tag, "_onehot"}, (j >= 0) ? 32'd1 : 32'd0, 32'd1);
            if (j >= 0) begin
                seen[j] = 1'b1;
                check({tag, "_blank"}, 32'(kif.blank), 32'(blanks[j]));
                if (!blanks[j]) check({tag, "_nib"}, 32'(kif.digit_nib), 32'(nibs[4*j +: 4]));
            end
        end
        check({tag, "_all_digits"}, 32'(seen), 32'hF);
    endtask

    bit pa [8]  = '{1, 1, 0, 1, 0, 1, 1, 0};
    bit pb [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int p0;
    int hold;

    initial begin
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;

        for (int i = 0; i < 46; i++) begin
            if (i < 10)      tv[i] = '{1'b1, 4'd5, (i == 5), (i >= 4) ? 1 : 0};
            else if (i < 20) tv[i] = '{1'b0, 4'd0, 1'b0, 1};
            else if (i < 28) tv[i] = '{pa[i-20], 4'd3, 1'b0, 1};
            else if (i < 36) tv[i] = '{1'b1, 4'd7, (i == 33), (i >= 32) ? 2 : 1};
            else             tv[i] = '{pb[i-36], 4'd7, 1'b0, 2};
        end

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_anode", 32'(kif.anode), 32'hE);
        check("rst_blank", 32'(kif.blank), 32'd1);
        check("rst_count", 32'(kif.entry_count), 32'd0);
        check("rst_pulse", 32'(kif.press_pulse), 32'd0);
        check("rst_nib", 32'(kif.digit_nib), 32'd0);

        // Clean press, press/release bounce
        for (int i = 0; i < 46; i++) begin
            kif.key_valid = tv[i].valid;
            kif.key_code  = tv[i].code;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse", i), 32'(kif.press_pulse), 32'(tv[i].exp_pulse));
            check($sformatf("vec%0d_count", i), 32'(kif.entry_count), tv[i].exp_count);
            @(negedge clk);
        end
        kif.key_valid = 1'b0;

        // Overflow: oldest digit discarded
        do_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd7);
        check("ovf_count", 32'(kif.entry_count), 32'd4);
        scan_check("ovf", {4'd2, 4'd3, 4'd4, 4'd7}, 4'b0000);

        // Two entries, two blank digits
        do_reset();
        press(4'd9); press(4'd6);
        check("scan_count", 32'(kif.entry_count), 32'd2);
        scan_check("scan", {4'd0, 4'd0, 4'd9, 4'd6}, 4'b1100);

        // Reset during PRESS_WAIT aborts the press
        do_reset();
        p0 = pulses_seen;
        @(negedge clk);
        kif.key_valid = 1'b1; kif.key_code = 4'd8;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; kif.key_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_pulses", pulses_seen - p0, 32'd0);
        check("midrst_count", 32'(kif.entry_count), 32'd0);

        // Clear key
        press(4'd1); press(4'd2); press(4'd3);
        p0 = pulses_seen;
        press(4'hC);
        check("clr_pulses", pulses_seen - p0, 32'd1);
`ifdef KEYPAD_CLEAR_KEY_EN
        check("clr_count", 32'(kif.entry_count), 32'd0);
        scan_check("clr", 16'h0000, 4'b1111);
`else
        check("clr_count", 32'(kif.entry_count), 32'd4);
        scan_check("clr", {4'd1, 4'd2, 4'd3, 4'hC}, 4'b0000);
`endif

        // Randomized segments against the reference model
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            kif.key_valid = 1'($urandom_range(0, 1));
            kif.key_code  = ($urandom_range(0, 5) == 0) ? 4'hC : 4'($urandom_range(0, 3));
            hold = $urandom_range(1, 8);
            repeat (hold) @(negedge clk);
        end
        kif.key_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
